mips_mem_system: RTL and testbench

Memory-side responder for the `mips` single-cycle core: serves instruction fetch on `pc`/`instr` and the data port on `aluout`/`writedata`/`MemWrite`/`readdata`. After reset it first runs a boot-load phase. A valid/ready word stream fills instruction memory while the core is held in reset. It then switches to run mode and answers core accesses. It sits beside `mips` in the top-level and owns both memories.

---
 rtl/mips_mem_pkg.sv | 14 +
 rtl/imem_loader.sv | 71 +++++++
 rtl/mips_mem_system.sv | 96 +++++++++
 tb/tb_mips_mem_system.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the mips memory-side responder.
package mips_mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int IMEM_WORDS_DEF = 256;
  localparam int DMEM_WORDS_DEF = 256;

  localparam logic [31:0] INSTR_NOP = 32'h0;

endpackage

// File: rtl/imem_loader.sv
// Boot-load controller: LOAD/RUN FSM, load pointer, handshake, overflow flag
// and the registered reset that holds the core while imem is filled.
module imem_loader
  import mips_mem_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_load_valid,
  input  logic [31:0]   i_load_data,
  input  logic          i_load_last,
  output logic          o_load_ready,
  output logic          o_load_overflow,
  output logic          o_core_reset,
  output logic          o_run,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [31:0]   o_wdata
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic          r_overflow;
  logic          r_core_reset;
  logic          w_accept;
  logic          w_at_end;

  assign w_accept = i_load_valid && (r_state == LOAD);
  assign w_at_end = (r_ptr == AW'(IMEM_WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == LOAD && w_accept && (i_load_last || w_at_end)) begin
      w_state_nxt = RUN;
    end
  end

  // The core reset falls on the same edge the FSM enters RUN.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state      <= LOAD;
      r_ptr        <= '0;
      r_overflow   <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (w_accept && w_at_end && !i_load_last) begin
        r_overflow <= 1'b1;
      end
      if (w_state_nxt == RUN) begin
        r_core_reset <= 1'b0;
      end
    end
  end

  // A word offered on the reset edge is discarded.
  assign o_we            = w_accept && !i_reset;
  assign o_waddr         = r_ptr;
  assign o_wdata         = i_load_data;
  assign o_load_ready    = (r_state == LOAD);
  assign o_run           = (r_state == RUN);
  assign o_load_overflow = r_overflow;
  assign o_core_reset    = r_core_reset;

endmodule

// File: rtl/mips_mem_system.sv
// Instruction and data memories for the single-cycle mips core, with a
// boot-load phase that fills imem before releasing the core from reset.
module mips_mem_system
  import mips_mem_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        core_reset,
  input  logic [63:0] pc,
  output logic [31:0] instr,
  input  logic        MemWrite,
  input  logic [63:0] aluout,
  input  logic [63:0] writedata,
  output logic [63:0] readdata,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_overflow,
  output logic        align_err
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0]    r_imem [IMEM_WORDS];
  logic [63:0]    r_dmem [DMEM_WORDS];
  logic           r_align_err;

  logic           w_run;
  logic           w_imem_we;
  logic [IAW-1:0] w_imem_waddr;
  logic [31:0]    w_imem_wdata;
  logic [IAW-1:0] w_pc_idx;
  logic           w_pc_oor;
  logic [DAW-1:0] w_d_idx;
  logic           w_d_oor;
  logic           w_dmem_we;
  logic           w_misalign;

  imem_loader #(
    .IMEM_WORDS (IMEM_WORDS),
    .AW         (IAW)
  ) u_loader (
    .clk             (clk),
    .i_reset         (reset),
    .i_load_valid    (load_valid),
    .i_load_data     (load_data),
    .i_load_last     (load_last),
    .o_load_ready    (load_ready),
    .o_load_overflow (load_overflow),
    .o_core_reset    (core_reset),
    .o_run           (w_run),
    .o_we            (w_imem_we),
    .o_waddr         (w_imem_waddr),
    .o_wdata         (w_imem_wdata)
  );

  assign w_pc_idx = pc[2 +: IAW];
  assign w_pc_oor = |pc[63:IAW+2];
  assign w_d_idx  = aluout[3 +: DAW];
  assign w_d_oor  = |aluout[63:DAW+3];

  always_ff @(posedge clk) begin
    if (w_imem_we) begin
      r_imem[w_imem_waddr] <= w_imem_wdata;
    end
  end

  assign w_dmem_we = w_run && MemWrite && !w_d_oor && !reset;

  always_ff @(posedge clk) begin
    if (w_dmem_we) begin
      r_dmem[w_d_idx] <= writedata;
    end
  end

  // Reads are not alignment-checked: aluout is live for non-memory ops too.
  assign w_misalign = (pc[1:0] != 2'b00) || (MemWrite && (aluout[2:0] != 3'b000));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_align_err <= 1'b0;
    end else if (w_run && w_misalign) begin
      r_align_err <= 1'b1;
    end
  end

  assign align_err = r_align_err;
  assign instr     = (w_run && !w_pc_oor) ? r_imem[w_pc_idx] : INSTR_NOP;
  assign readdata  = (w_run && !w_d_oor)  ? r_dmem[w_d_idx]  : 64'h0;

endmodule

// File: tb/tb_mips_mem_system.sv
// Directed scoreboard bench for mips_mem_system: boot load, overflow,
// mid-load reset, data read/write timing, range and alignment flags.
module tb_mips_mem_system;

  localparam int IW = 256;
  localparam int DW = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_reset;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        MemWrite;
  logic [63:0] aluout;
  logic [63:0] writedata;
  logic [63:0] readdata;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_overflow;
  logic        align_err;

  mips_mem_system #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .core_reset    (core_reset),
    .pc            (pc),
    .instr         (instr),
    .MemWrite      (MemWrite),
    .aluout        (aluout),
    .writedata     (writedata),
    .readdata      (readdata),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .load_overflow (load_overflow),
    .align_err     (align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc = '0; MemWrite = 1'b0; aluout = '0; writedata = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    push("rst_core_reset", 64'd1);   chk({63'd0, core_reset});
    push("rst_load_ready", 64'd1);   chk({63'd0, load_ready});
    push("rst_overflow", 64'd0);     chk({63'd0, load_overflow});
    push("rst_align_err", 64'd0);    chk({63'd0, align_err});
    push("rst_instr", 64'd0);        chk({32'd0, instr});
    push("rst_readdata", 64'd0);     chk(readdata);

    // Overflow: IW words without load_last, zeros except the final word.
    for (int i = 0; i < IW; i++) begin
      load_valid = 1'b1;
      load_data  = (i == IW - 1) ? 32'hFEEDF00D : 32'h0;
      load_last  = 1'b0;
      if (i == IW - 1) begin
        settle();
        push("ovf_ready_before_last", 64'd1); chk({63'd0, load_ready});
        push("ovf_flag_before_last", 64'd0);  chk({63'd0, load_overflow});
      end
      tick();
    end
    push("ovf_flag", 64'd1);       chk({63'd0, load_overflow});
    push("ovf_ready_drop", 64'd0); chk({63'd0, load_ready});
    push("ovf_core_run", 64'd0);   chk({63'd0, core_reset});
    load_data = 32'h12345678;
    tick();
    load_valid = 1'b0;
    pc = 64'd0; settle();
    push("ovf_extra_not_written", 64'd0); chk({32'd0, instr});
    pc = 64'(4 * IW - 4); settle();
    push("ovf_last_word", 64'hFEEDF00D);  chk({32'd0, instr});
    pc = 64'(4 * IW); settle();
    push("pc_out_of_range", 64'd0);       chk({32'd0, instr});
    pc = 64'd0;

    // Reset mid-load after 2 of 4 words; the reset-edge word is discarded.
    reset = 1'b1; tick(); reset = 1'b0;
    load_word(32'h11111111, 1'b0);
    load_word(32'h22222222, 1'b0);
    settle();
    push("load_instr_zero", 64'd0); chk({32'd0, instr});
    reset = 1'b1; load_valid = 1'b1; load_data = 32'h99999999;
    tick();
    reset = 1'b0; load_valid = 1'b0;
    push("mid_core_reset", 64'd1);   chk({63'd0, core_reset});
    push("mid_ready", 64'd1);        chk({63'd0, load_ready});
    push("mid_overflow_clr", 64'd0); chk({63'd0, load_overflow});

    // MemWrite during LOAD must be ignored and readdata held at zero.
    MemWrite = 1'b1; aluout = 64'h10; writedata = 64'hBADBAD; settle();
    push("load_readdata_zero", 64'd0); chk(readdata);
    tick();
    MemWrite = 1'b0;

    load_word(32'h20080005, 1'b0);
    push("boot_ready_mid", 64'd1);  chk({63'd0, load_ready});
    push("boot_core_mid", 64'd1);   chk({63'd0, core_reset});
    load_word(32'h20090007, 1'b0);
    load_word(32'h01095020, 1'b1);
    push("boot_ready_drop", 64'd0); chk({63'd0, load_ready});
    push("boot_core_fall", 64'd0);  chk({63'd0, core_reset});
    pc = 64'd0;  settle(); push("fetch_pc0", 64'h20080005);  chk({32'd0, instr});
    pc = 64'd4;  settle(); push("fetch_pc4", 64'h20090007);  chk({32'd0, instr});
    pc = 64'd8;  settle(); push("fetch_pc8", 64'h01095020);  chk({32'd0, instr});
    pc = 64'd12; settle(); push("fetch_pc12", 64'd0);        chk({32'd0, instr});
    pc = 64'd0;

    // Data port: same-cycle read-before-write, then new value next cycle.
    MemWrite = 1'b1; aluout = 64'h10; writedata = 64'h0123456789ABCDEF;
    tick();
    writedata = 64'hDEADBEEF_CAFEF00D; settle();
    push("wr_same_cycle_old", 64'h0123456789ABCDEF); chk(readdata);
    tick();
    MemWrite = 1'b0; settle();
    push("wr_next_cycle_new", 64'hDEADBEEF_CAFEF00D); chk(readdata);
    MemWrite = 1'b1; aluout = 64'h0; writedata = 64'h5555AAAA_3333CCCC;
    tick();
    aluout = 64'(8 * DW); writedata = 64'h0BAD; settle();
    push("oor_readdata", 64'd0); chk(readdata);
    tick();
    MemWrite = 1'b0; aluout = 64'h0; settle();
    push("oor_no_alias_write", 64'h5555AAAA_3333CCCC); chk(readdata);
    push("oor_align_clean", 64'd0); chk({63'd0, align_err});

    // Misaligned store sets the sticky flag.
    MemWrite = 1'b1; aluout = 64'h3; writedata = 64'h77;
    tick();
    MemWrite = 1'b0; aluout = 64'h10;
    push("store_align_err", 64'd1); chk({63'd0, align_err});
    tick();
    push("store_align_sticky", 64'd1); chk({63'd0, align_err});

    // Misaligned fetch after a fresh boot; word is still returned.
    reset = 1'b1; tick(); reset = 1'b0;
    push("rst2_align_clr", 64'd0); chk({63'd0, align_err});
    load_word(32'hABCD0001, 1'b1);
    pc = 64'h2; settle();
    push("fetch_misalign_word", 64'hABCD0001); chk({32'd0, instr});
    tick();
    pc = 64'h0;
    push("fetch_align_err", 64'd1); chk({63'd0, align_err});
    tick();
    push("fetch_align_sticky", 64'd1); chk({63'd0, align_err});
    push("dmem_kept_over_reset", 64'hDEADBEEF_CAFEF00D); chk(readdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
